// File: rtl/fpu_div_sqrt_arbiter.sv
// fpu_div_sqrt_arbiter
//
// This block shares one iterative divide/square-root unit between up to
// eight requesters. It handles one transaction at a time:
//   1. A round-robin grant picks a requester.
//   2. The arbiter latches that requester's operands and sends a one-cycle
//      start pulse to the unit.
//   3. It waits for the unit's done pulse.
//   4. It holds the result for the owning requester until that requester
//      accepts it.
//
// Parameters
//   C_NUM_REQ  number of requesters (2..8)
//   C_OP_W     operand / result width
//   C_TIMEOUT  watchdog limit in WAIT cycles (used only with the macro)
//
// Optional feature
//   `define FPU_DIV_SQRT_ARB_TIMEOUT_EN turns on a watchdog. When an
//   operation spends C_TIMEOUT cycles in WAIT without a done pulse, the
//   watchdog kills the unit. It then returns result 0 with the Timeout
//   flag set. Without the macro there is no counter, and the Timeout flag
//   is constant 0.
//
// Ports
//   Clk_CI, Rst_RI         clock; synchronous active-high reset
//   Flush_SI               abort the in-flight operation (ISSUE/WAIT only)
//   Req_valid_SI           per-requester request valid
//   Req_ready_SO           per-requester grant (combinational, IDLE only)
//   Req_sqrt_SI            per-requester op select, 1 = sqrt, 0 = div
//   Req_a_DI, Req_b_DI     packed operands, requester i at slice i
//   Req_rm_DI              packed 3-bit rounding modes
//   Unit_div_start_SO      one-cycle start pulse for a divide
//   Unit_sqrt_start_SO     one-cycle start pulse for a square root
//   Unit_kill_SO           one-cycle kill pulse for the unit
//   Unit_a_DO, Unit_b_DO   registered operands for the unit
//   Unit_rm_DO             registered rounding mode for the unit
//   Unit_done_SI           unit result valid pulse
//   Unit_res_DI            unit result
//   Unit_flags_DI          unit flags {Exp_OF, Exp_UF, Div_zero}
//   Resp_valid_SO          response valid, only the owner's bit is set
//   Resp_ready_SI          per-requester response accept
//   Resp_res_DO            held result
//   Resp_flags_DO          held flags {Timeout, Exp_OF, Exp_UF, Div_zero}

module fpu_div_sqrt_arbiter #(
  parameter int C_NUM_REQ = 2,
  parameter int C_OP_W    = 32,
  parameter int C_TIMEOUT = 64
) (
  input  logic                        Clk_CI,
  input  logic                        Rst_RI,
  input  logic                        Flush_SI,
  input  logic [C_NUM_REQ-1:0]        Req_valid_SI,
  output logic [C_NUM_REQ-1:0]        Req_ready_SO,
  input  logic [C_NUM_REQ-1:0]        Req_sqrt_SI,
  input  logic [C_NUM_REQ*C_OP_W-1:0] Req_a_DI,
  input  logic [C_NUM_REQ*C_OP_W-1:0] Req_b_DI,
  input  logic [C_NUM_REQ*3-1:0]      Req_rm_DI,
  output logic                        Unit_div_start_SO,
  output logic                        Unit_sqrt_start_SO,
  output logic                        Unit_kill_SO,
  output logic [C_OP_W-1:0]           Unit_a_DO,
  output logic [C_OP_W-1:0]           Unit_b_DO,
  output logic [2:0]                  Unit_rm_DO,
  input  logic                        Unit_done_SI,
  input  logic [C_OP_W-1:0]           Unit_res_DI,
  input  logic [2:0]                  Unit_flags_DI,
  output logic [C_NUM_REQ-1:0]        Resp_valid_SO,
  input  logic [C_NUM_REQ-1:0]        Resp_ready_SI,
  output logic [C_OP_W-1:0]           Resp_res_DO,
  output logic [3:0]                  Resp_flags_DO
);

  localparam int OWN_W = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;

  if (C_NUM_REQ < 2 || C_NUM_REQ > 8 || C_OP_W < 1 || C_TIMEOUT < 1) begin : g_param_check
    $error("fpu_div_sqrt_arbiter: illegal parameter value");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [OWN_W-1:0]      ptr_q;
  logic [OWN_W-1:0]      owner_q;
  logic                  op_sqrt_q;

  logic                  grant_found;
  logic [OWN_W-1:0]      grant_idx;
  logic [OWN_W:0]        cand_w;
  logic [OWN_W-1:0]      cand;
  logic [C_OP_W-1:0]     sel_a, sel_b;
  logic [2:0]            sel_rm;
  logic                  sel_sqrt;
  logic [OWN_W-1:0]      ptr_next;

  logic                  resp_accept;
  logic                  timeout_hit;
  logic                  kill_c, div_start_c, sqrt_start_c;

  // Round-robin search. Start at the pointer and wrap modulo C_NUM_REQ.
  // The first valid requester found wins. The wrap is done by explicit
  // subtraction so that non-power-of-two requester counts work.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_w      = '0;
    cand        = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      cand_w = {1'b0, ptr_q} + (OWN_W+1)'(i);
      if (cand_w >= (OWN_W+1)'(C_NUM_REQ)) begin
        cand_w = cand_w - (OWN_W+1)'(C_NUM_REQ);
      end
      cand = cand_w[OWN_W-1:0];
      if (!grant_found && Req_valid_SI[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Select the granted requester's operands, op and rounding mode out of
  // the packed buses. Using constant slice positions keeps the mux
  // simple.
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_rm   = '0;
    sel_sqrt = 1'b0;
    for (int j = 0; j < C_NUM_REQ; j++) begin
      if (grant_idx == OWN_W'(j)) begin
        sel_a    = Req_a_DI[j*C_OP_W +: C_OP_W];
        sel_b    = Req_b_DI[j*C_OP_W +: C_OP_W];
        sel_rm   = Req_rm_DI[j*3 +: 3];
        sel_sqrt = Req_sqrt_SI[j];
      end
    end
    if (grant_idx == OWN_W'(C_NUM_REQ-1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_idx + OWN_W'(1);
    end
  end

  assign resp_accept = (state_q == RESP) && Resp_ready_SI[owner_q];

`ifdef FPU_DIV_SQRT_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(C_TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;

  // The watchdog counts the cycles spent in WAIT. It clears whenever the
  // FSM is anywhere else, so every operation starts from zero.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI || state_q != WAIT) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WD_W'(1);
    end
  end

  assign timeout_hit = (state_q == WAIT) && (wd_q == WD_W'(C_TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and pulse decode. Flush takes priority over done, and done
  // takes priority over the watchdog. A flush during ISSUE suppresses the
  // start pulse, so the unit only ever sees the kill.
  always_comb begin
    state_d      = state_q;
    kill_c       = 1'b0;
    div_start_c  = 1'b0;
    sqrt_start_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) state_d = ISSUE;
      end
      ISSUE: begin
        if (Flush_SI) begin
          kill_c  = 1'b1;
          state_d = IDLE;
        end else begin
          div_start_c  = ~op_sqrt_q;
          sqrt_start_c = op_sqrt_q;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (Flush_SI) begin
          kill_c  = 1'b1;
          state_d = IDLE;
        end else if (Unit_done_SI) begin
          state_d = RESP;
        end else if (timeout_hit) begin
          kill_c  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The combinational outputs are forced low while reset is asserted. A
  // reset in WAIT therefore drops the operation without a kill pulse.
  assign Unit_kill_SO       = kill_c & ~Rst_RI;
  assign Unit_div_start_SO  = div_start_c & ~Rst_RI;
  assign Unit_sqrt_start_SO = sqrt_start_c & ~Rst_RI;
  assign Req_ready_SO  = (state_q == IDLE && grant_found && !Rst_RI)
                         ? (C_NUM_REQ'(1) << grant_idx) : '0;
  assign Resp_valid_SO = (state_q == RESP && !Rst_RI)
                         ? (C_NUM_REQ'(1) << owner_q) : '0;

  // State, pointer, operand and result registers. Operands are latched at
  // grant time, so they stay stable through ISSUE and WAIT. The result is
  // held from the done pulse until the owner accepts it. Done pulses
  // outside WAIT never reach the holding register.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      op_sqrt_q     <= 1'b0;
      Unit_a_DO     <= '0;
      Unit_b_DO     <= '0;
      Unit_rm_DO    <= '0;
      Resp_res_DO   <= '0;
      Resp_flags_DO <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && grant_found) begin
        owner_q    <= grant_idx;
        ptr_q      <= ptr_next;
        op_sqrt_q  <= sel_sqrt;
        Unit_a_DO  <= sel_a;
        Unit_b_DO  <= sel_b;
        Unit_rm_DO <= sel_rm;
      end
      if (state_q == WAIT && !Flush_SI) begin
        if (Unit_done_SI) begin
          Resp_res_DO   <= Unit_res_DI;
          Resp_flags_DO <= {1'b0, Unit_flags_DI};
        end else if (timeout_hit) begin
          Resp_res_DO   <= '0;
          Resp_flags_DO <= 4'b1000;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_div_sqrt_arbiter.sv
// tb_fpu_div_sqrt_arbiter
//
// This bench runs directed scenarios against fpu_div_sqrt_arbiter with two
// requesters, 32-bit operands and C_TIMEOUT = 8. The bench itself plays
// the part of the div/sqrt unit and drives the done pulses by hand. Each
// scenario task compares DUT outputs against hand-computed values. Inputs
// change 2 time units after the rising edge, and outputs are sampled 1
// time unit after that.

module tb_fpu_div_sqrt_arbiter;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int TO = 8;

  logic           Clk_CI = 1'b0;
  logic           Rst_RI;
  logic           Flush_SI;
  logic [N-1:0]   Req_valid_SI;
  logic [N-1:0]   Req_ready_SO;
  logic [N-1:0]   Req_sqrt_SI;
  logic [N*W-1:0] Req_a_DI;
  logic [N*W-1:0] Req_b_DI;
  logic [N*3-1:0] Req_rm_DI;
  logic           Unit_div_start_SO;
  logic           Unit_sqrt_start_SO;
  logic           Unit_kill_SO;
  logic [W-1:0]   Unit_a_DO;
  logic [W-1:0]   Unit_b_DO;
  logic [2:0]     Unit_rm_DO;
  logic           Unit_done_SI;
  logic [W-1:0]   Unit_res_DI;
  logic [2:0]     Unit_flags_DI;
  logic [N-1:0]   Resp_valid_SO;
  logic [N-1:0]   Resp_ready_SI;
  logic [W-1:0]   Resp_res_DO;
  logic [3:0]     Resp_flags_DO;

  int errors = 0;
  int checks = 0;

  always #5 Clk_CI = ~Clk_CI;

  fpu_div_sqrt_arbiter #(.C_NUM_REQ(N), .C_OP_W(W), .C_TIMEOUT(TO)) dut (
    .Clk_CI(Clk_CI), .Rst_RI(Rst_RI), .Flush_SI(Flush_SI),
    .Req_valid_SI(Req_valid_SI), .Req_ready_SO(Req_ready_SO),
    .Req_sqrt_SI(Req_sqrt_SI), .Req_a_DI(Req_a_DI), .Req_b_DI(Req_b_DI),
    .Req_rm_DI(Req_rm_DI), .Unit_div_start_SO(Unit_div_start_SO),
    .Unit_sqrt_start_SO(Unit_sqrt_start_SO), .Unit_kill_SO(Unit_kill_SO),
    .Unit_a_DO(Unit_a_DO), .Unit_b_DO(Unit_b_DO), .Unit_rm_DO(Unit_rm_DO),
    .Unit_done_SI(Unit_done_SI), .Unit_res_DI(Unit_res_DI),
    .Unit_flags_DI(Unit_flags_DI), .Resp_valid_SO(Resp_valid_SO),
    .Resp_ready_SI(Resp_ready_SI), .Resp_res_DO(Resp_res_DO),
    .Resp_flags_DO(Resp_flags_DO)
  );

  task automatic tick();
    @(posedge Clk_CI);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    Rst_RI = 1'b1; Flush_SI = 1'b0; Req_valid_SI = 2'b11; Req_sqrt_SI = '0;
    Req_a_DI = '0; Req_b_DI = '0; Req_rm_DI = '0; Unit_done_SI = 1'b0;
    Unit_res_DI = '0; Unit_flags_DI = '0; Resp_ready_SI = '0;
    tick(); tick(); settle();
    checks++; if (Req_ready_SO !== 2'b00) begin errors++; $display("[TB] FAIL reset_req_ready got=%b want=00", Req_ready_SO); end
    checks++; if (Resp_valid_SO !== 2'b00 || Unit_kill_SO !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_kill got=%b/%b want=00/0", Resp_valid_SO, Unit_kill_SO); end
    checks++; if (Unit_a_DO !== '0 || Resp_res_DO !== '0 || Resp_flags_DO !== 4'h0) begin errors++; $display("[TB] FAIL reset_regs a=%h res=%h flags=%b want 0", Unit_a_DO, Resp_res_DO, Resp_flags_DO); end
    Req_valid_SI = 2'b00;
    Rst_RI = 1'b0;
    tick();
  endtask

  task automatic test_single_div();
    Req_valid_SI = 2'b01; Req_sqrt_SI = 2'b00;
    Req_a_DI = {32'hDEADBEEF, 32'h40400000};
    Req_b_DI = {32'h12345678, 32'h3F800000};
    Req_rm_DI = {3'b111, 3'b010};
    settle();
    checks++; if (Req_ready_SO !== 2'b01) begin errors++; $display("[TB] FAIL div_c0_ready got=%b want=01", Req_ready_SO); end
    tick(); Req_valid_SI = 2'b00; settle();
    checks++; if (Unit_div_start_SO !== 1'b1 || Unit_sqrt_start_SO !== 1'b0) begin errors++; $display("[TB] FAIL div_c1_start got div=%b sqrt=%b want 1/0", Unit_div_start_SO, Unit_sqrt_start_SO); end
    checks++; if (Unit_a_DO !== 32'h40400000 || Unit_b_DO !== 32'h3F800000 || Unit_rm_DO !== 3'b010) begin errors++; $display("[TB] FAIL div_c1_operands got %h %h %b", Unit_a_DO, Unit_b_DO, Unit_rm_DO); end
    for (int c = 2; c <= 11; c++) begin
      tick(); settle();
      checks++; if (Unit_div_start_SO !== 1'b0 || Resp_valid_SO !== 2'b00) begin errors++; $display("[TB] FAIL div_wait_c%0d start=%b resp=%b want 0/00", c, Unit_div_start_SO, Resp_valid_SO); end
      checks++; if (Unit_a_DO !== 32'h40400000 || Unit_b_DO !== 32'h3F800000) begin errors++; $display("[TB] FAIL div_stable_c%0d a=%h b=%h", c, Unit_a_DO, Unit_b_DO); end
    end
    tick(); Unit_done_SI = 1'b1; Unit_res_DI = 32'h40400000; Unit_flags_DI = 3'b000; settle();
    checks++; if (Resp_valid_SO !== 2'b00) begin errors++; $display("[TB] FAIL div_c12_resp got=%b want=00", Resp_valid_SO); end
    tick(); Unit_done_SI = 1'b0; Resp_ready_SI = 2'b01; settle();
    checks++; if (Resp_valid_SO !== 2'b01 || Resp_res_DO !== 32'h40400000 || Resp_flags_DO !== 4'b0000) begin errors++; $display("[TB] FAIL div_c13_resp got v=%b res=%h f=%b want 01/40400000/0000", Resp_valid_SO, Resp_res_DO, Resp_flags_DO); end
    tick(); Resp_ready_SI = 2'b00; settle();
    checks++; if (Resp_valid_SO !== 2'b00) begin errors++; $display("[TB] FAIL div_c14_idle got=%b want=00", Resp_valid_SO); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_oh;
    int         exp_own;
    Rst_RI = 1'b1; tick(); Rst_RI = 1'b0;
    Req_valid_SI = 2'b11; Req_sqrt_SI = 2'b10; Resp_ready_SI = 2'b11;
    Req_a_DI = {32'h41000000, 32'h40800000};
    for (int t = 0; t < 4; t++) begin
      exp_own = t % 2;
      exp_oh  = (exp_own == 1) ? 2'b10 : 2'b01;
      settle();
      checks++; if (Req_ready_SO !== exp_oh) begin errors++; $display("[TB] FAIL rr_grant%0d got=%b want=%b", t, Req_ready_SO, exp_oh); end
      tick(); settle();
      checks++; if (Unit_sqrt_start_SO !== exp_own[0] || Unit_div_start_SO !== ~exp_own[0] || Req_ready_SO !== 2'b00) begin errors++; $display("[TB] FAIL rr_issue%0d sqrt=%b div=%b ready=%b", t, Unit_sqrt_start_SO, Unit_div_start_SO, Req_ready_SO); end
      tick(); Unit_done_SI = 1'b1; Unit_res_DI = 32'h10000000 + t; Unit_flags_DI = 3'(t); settle();
      checks++; if (Resp_valid_SO !== 2'b00) begin errors++; $display("[TB] FAIL rr_wait%0d resp=%b want=00", t, Resp_valid_SO); end
      tick(); Unit_done_SI = 1'b0; settle();
      checks++; if (Resp_valid_SO !== exp_oh || Resp_res_DO !== 32'h10000000 + t || Resp_flags_DO !== {1'b0, 3'(t)}) begin errors++; $display("[TB] FAIL rr_resp%0d v=%b res=%h f=%b want v=%b", t, Resp_valid_SO, Resp_res_DO, Resp_flags_DO, exp_oh); end
      checks++; if (Req_ready_SO !== 2'b00) begin errors++; $display("[TB] FAIL rr_resp_noready%0d got=%b want=00", t, Req_ready_SO); end
      tick();
    end
    Req_valid_SI = 2'b00; Resp_ready_SI = 2'b00;
  endtask

  task automatic test_resp_stall();
    Req_valid_SI = 2'b01; Req_sqrt_SI = 2'b01;
    Req_a_DI = {32'h0, 32'h40000000};
    settle();
    checks++; if (Req_ready_SO !== 2'b01) begin errors++; $display("[TB] FAIL stall_grant got=%b want=01", Req_ready_SO); end
    tick(); Req_valid_SI = 2'b00;
    tick(); Unit_done_SI = 1'b1; Unit_res_DI = 32'h3FB504F3; Unit_flags_DI = 3'b010;
    tick(); Unit_done_SI = 1'b0; Req_valid_SI = 2'b11; Resp_ready_SI = 2'b00;
    for (int c = 0; c < 5; c++) begin
      Flush_SI = (c == 1);
      Unit_done_SI = (c == 2);
      Unit_res_DI = 32'hFFFFFFFF; Unit_flags_DI = 3'b111;
      settle();
      checks++; if (Resp_valid_SO !== 2'b01 || Resp_res_DO !== 32'h3FB504F3 || Resp_flags_DO !== 4'b0010) begin errors++; $display("[TB] FAIL stall_hold%0d v=%b res=%h f=%b want 01/3fb504f3/0010", c, Resp_valid_SO, Resp_res_DO, Resp_flags_DO); end
      checks++; if (Req_ready_SO !== 2'b00 || Unit_kill_SO !== 1'b0) begin errors++; $display("[TB] FAIL stall_noready%0d ready=%b kill=%b want 00/0", c, Req_ready_SO, Unit_kill_SO); end
      tick();
    end
    Flush_SI = 1'b0; Unit_done_SI = 1'b0; Resp_ready_SI = 2'b01;
    settle();
    checks++; if (Resp_valid_SO !== 2'b01 || Resp_res_DO !== 32'h3FB504F3) begin errors++; $display("[TB] FAIL stall_final v=%b res=%h", Resp_valid_SO, Resp_res_DO); end
    tick(); Resp_ready_SI = 2'b00; settle();
    checks++; if (Resp_valid_SO !== 2'b00 || Req_ready_SO !== 2'b10) begin errors++; $display("[TB] FAIL stall_release v=%b ready=%b want 00/10", Resp_valid_SO, Req_ready_SO); end
    Req_valid_SI = 2'b00;
  endtask

  task automatic test_flush();
    Req_valid_SI = 2'b10; Req_sqrt_SI = 2'b00;
    settle();
    checks++; if (Req_ready_SO !== 2'b10) begin errors++; $display("[TB] FAIL flush_grant got=%b want=10", Req_ready_SO); end
    tick(); Req_valid_SI = 2'b00; settle();
    checks++; if (Unit_div_start_SO !== 1'b1 || Unit_kill_SO !== 1'b0) begin errors++; $display("[TB] FAIL flush_issue div=%b kill=%b want 1/0", Unit_div_start_SO, Unit_kill_SO); end
    tick(); Flush_SI = 1'b1; Unit_done_SI = 1'b1; Unit_res_DI = 32'hCAFEF00D; settle();
    checks++; if (Unit_kill_SO !== 1'b1) begin errors++; $display("[TB] FAIL flush_wait_kill got=%b want=1", Unit_kill_SO); end
    tick(); Flush_SI = 1'b0; Unit_done_SI = 1'b0; Req_valid_SI = 2'b01; settle();
    checks++; if (Resp_valid_SO !== 2'b00 || Unit_kill_SO !== 1'b0 || Req_ready_SO !== 2'b01) begin errors++; $display("[TB] FAIL flush_idle v=%b kill=%b ready=%b want 00/0/01", Resp_valid_SO, Unit_kill_SO, Req_ready_SO); end
    tick(); Req_valid_SI = 2'b00; Flush_SI = 1'b1; settle();
    checks++; if (Unit_div_start_SO !== 1'b0 || Unit_kill_SO !== 1'b1) begin errors++; $display("[TB] FAIL flush_issue_suppress div=%b kill=%b want 0/1", Unit_div_start_SO, Unit_kill_SO); end
    tick(); Flush_SI = 1'b0; Req_valid_SI = 2'b10; settle();
    checks++; if (Req_ready_SO !== 2'b10 || Unit_kill_SO !== 1'b0) begin errors++; $display("[TB] FAIL flush_issue_idle ready=%b kill=%b want 10/0", Req_ready_SO, Unit_kill_SO); end
    Req_valid_SI = 2'b00;
  endtask

  task automatic test_reset_in_wait();
    Req_valid_SI = 2'b01; Req_sqrt_SI = 2'b00;
    Req_a_DI = {32'h0, 32'h40A00000}; Req_b_DI = {32'h0, 32'h40000000};
    tick(); Req_valid_SI = 2'b00;
    tick(); tick();
    Rst_RI = 1'b1;
    tick(); Rst_RI = 1'b0; settle();
    checks++; if (Unit_a_DO !== '0 || Unit_b_DO !== '0 || Unit_rm_DO !== 3'b000) begin errors++; $display("[TB] FAIL rstwait_operands a=%h b=%h rm=%b want 0", Unit_a_DO, Unit_b_DO, Unit_rm_DO); end
    checks++; if (Resp_valid_SO !== 2'b00 || Unit_kill_SO !== 1'b0 || Resp_res_DO !== '0) begin errors++; $display("[TB] FAIL rstwait_outputs v=%b kill=%b res=%h want 0", Resp_valid_SO, Unit_kill_SO, Resp_res_DO); end
    Req_valid_SI = 2'b11; settle();
    checks++; if (Req_ready_SO !== 2'b01) begin errors++; $display("[TB] FAIL rstwait_ptr got=%b want=01", Req_ready_SO); end
    Req_valid_SI = 2'b10; settle();
    checks++; if (Req_ready_SO !== 2'b10) begin errors++; $display("[TB] FAIL rstwait_req1 got=%b want=10", Req_ready_SO); end
    tick(); Req_valid_SI = 2'b00;
    tick(); Unit_done_SI = 1'b1; Unit_res_DI = 32'h00000055; Unit_flags_DI = 3'b001;
    tick(); Unit_done_SI = 1'b0; Resp_ready_SI = 2'b10; settle();
    checks++; if (Resp_valid_SO !== 2'b10 || Resp_res_DO !== 32'h00000055 || Resp_flags_DO !== 4'b0001) begin errors++; $display("[TB] FAIL rstwait_resp v=%b res=%h f=%b want 10/55/0001", Resp_valid_SO, Resp_res_DO, Resp_flags_DO); end
    tick(); Resp_ready_SI = 2'b00;
  endtask

`ifdef FPU_DIV_SQRT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    Req_valid_SI = 2'b01; Req_sqrt_SI = 2'b00;
    tick(); Req_valid_SI = 2'b00;
    for (int k = 1; k <= TO; k++) begin
      tick(); settle();
      checks++; if (Unit_kill_SO !== (k == TO)) begin errors++; $display("[TB] FAIL timeout_kill_w%0d got=%b want=%b", k, Unit_kill_SO, (k == TO)); end
    end
    tick(); Resp_ready_SI = 2'b01; settle();
    checks++; if (Resp_valid_SO !== 2'b01 || Resp_res_DO !== '0 || Resp_flags_DO !== 4'b1000) begin errors++; $display("[TB] FAIL timeout_resp v=%b res=%h f=%b want 01/0/1000", Resp_valid_SO, Resp_res_DO, Resp_flags_DO); end
    tick(); Resp_ready_SI = 2'b00;
  endtask
`endif

  initial begin
    test_reset();
    test_single_div();
    test_round_robin();
    test_resp_stall();
    test_flush();
    test_reset_in_wait();
`ifdef FPU_DIV_SQRT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
